// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Op decode is two bits: bit1 selects divide, bit0 selects signed.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_abs_neg.sv
// Conditional two's complement, used for operand magnitudes
// and for restoring the sign of products, quotients and remainders.
module mult_div_unit_abs_neg #(
  parameter int N = 16
) (
  input  logic         neg_i,
  input  logic [N-1:0] val_i,
  output logic [N-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(N-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Shift-add multiply and restoring divide on operand magnitudes.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             lo_zero
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q;
  op_e              op_q;
  logic             sa_q, sb_q;
  logic [WIDTH-1:0] b_q, a_raw_q;
  logic [W2-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dbz_q;

  logic             sa_d, sb_d;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign sa_d = is_signed(op_e'(op)) & operand_a[WIDTH-1];
  assign sb_d = is_signed(op_e'(op)) & operand_b[WIDTH-1];

  mult_div_unit_abs_neg #(.N(WIDTH)) u_abs_a (
    .neg_i(sa_d), .val_i(operand_a), .val_o(a_abs)
  );
  mult_div_unit_abs_neg #(.N(WIDTH)) u_abs_b (
    .neg_i(sb_d), .val_i(operand_b), .val_o(b_abs)
  );

  // Multiply: multiplier sits in the low half and shifts out LSB first.
  logic [WIDTH:0]  msum;
  logic [W2-1:0]   mul_d;
  assign msum  = {1'b0, acc_q[W2-1:WIDTH]}
               + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign mul_d = {msum, acc_q[WIDTH-1:1]};

  // Divide: remainder in the high half, quotient bits shift in at the LSB.
  logic [WIDTH:0]  rsh, dif;
  logic [W2-1:0]   div_d;
  assign rsh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign dif   = rsh - {1'b0, b_q};
  assign div_d = dif[WIDTH]
               ? {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
               : {dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  mult_div_unit_abs_neg #(.N(W2)) u_neg_p (
    .neg_i(sa_q ^ sb_q), .val_i(acc_q), .val_o(prod_s)
  );
  mult_div_unit_abs_neg #(.N(WIDTH)) u_neg_q (
    .neg_i(sa_q ^ sb_q), .val_i(acc_q[WIDTH-1:0]), .val_o(quo_s)
  );
  mult_div_unit_abs_neg #(.N(WIDTH)) u_neg_r (
    .neg_i(sa_q), .val_i(acc_q[W2-1:WIDTH]), .val_o(rem_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MULTU;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      b_q     <= '0;
      a_raw_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            b_q     <= b_abs;
            a_raw_q <= operand_a;
            acc_q   <= {{WIDTH{1'b0}}, a_abs};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // One settle cycle after the last iteration keeps latency fixed.
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_q <= FIX;
          end else begin
            acc_q <= is_div(op_q) ? div_d : mul_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          if (!is_div(op_q)) begin
            hi_q  <= prod_s[W2-1:WIDTH];
            lo_q  <= prod_s[WIDTH-1:0];
            dbz_q <= 1'b0;
          end else if (b_q == '0) begin
            hi_q  <= a_raw_q;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q  <= rem_s;
            lo_q  <= quo_s;
            dbz_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign lo_zero     = (lo_q == '0);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH=16.
// Checks results, flags and the fixed 18-cycle latency.
module tb_mult_div_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dbz, lo_zero;
  logic [W-1:0] hi, lo;

  int cyc = 0;
  int acc_cyc = 0;
  int npass = 0;
  int ntot = 0;
  int seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .operand_a(a),
    .operand_b(b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(dbz),
    .lo_zero(lo_zero)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Accept on the next edge, then scramble inputs to prove capture.
  task automatic issue(input logic [1:0] o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [1:0] o,
                     input logic [W-1:0] x,
                     input logic [W-1:0] y,
                     input logic [W-1:0] ehi,
                     input logic [W-1:0] elo,
                     input logic edbz);
    issue(o, x, y);
    wait_done();
    chk({tag, "_lat"}, cyc - acc_cyc, 18);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dbz"}, dbz, edbz);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_loz", lo_zero, 1);

    run("multu_ff", 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 0);
    run("mult_neg", 2'b01, 16'hFFFE, 16'h0003, 16'hFFFF, 16'hFFFA, 0);
    run("mult_min", 2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 0);
    run("div_neg", 2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 0);
    run("div_nd", 2'b11, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 0);
    run("divu", 2'b10, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 0);
    run("divu_z", 2'b10, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1);
    run("multu_s", 2'b00, 16'h0002, 16'h0003, 16'h0000, 16'h0006, 0);
    run("div_z", 2'b11, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1);
    run("div_ovf", 2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 0);
    chk("ovf_loz", lo_zero, 0);
    run("multu_0", 2'b00, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0);
    chk("zero_loz", lo_zero, 1);

    // start while busy must not disturb the running op
    issue(2'b00, 16'h0003, 16'h0005);
    repeat (4) @(posedge clk);
    #1;
    chk("ign_busy", busy, 1);
    op = 2'b10; a = 16'h0009; b = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("ign_lat", cyc - acc_cyc, 18);
    chk("ign_hi", hi, 16'h0000);
    chk("ign_lo", lo, 16'h000F);

    // back-to-back start on the done cycle
    issue(2'b11, 16'h0064, 16'h0007);
    wait_done();
    chk("b2b_lat", cyc - acc_cyc, 18);
    chk("b2b_lo", lo, 16'h000E);
    issue(2'b00, 16'h0010, 16'h0010);
    wait_done();
    chk("b2b2_lat", cyc - acc_cyc, 18);
    chk("b2b2_hi", hi, 16'h0000);
    chk("b2b2_lo", lo, 16'h0100);

    // reset mid-divide aborts without a done pulse
    issue(2'b11, 16'h0064, 16'h0007);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    chk("ab_pre_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_hi", hi, 0);
    chk("ab_lo", lo, 0);
    chk("ab_done", done, 0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("ab_nodone", seen, 0);
    chk("ab_idle", busy, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
